// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions: major opcodes, instruction formats and the
// canonical NOP used when a descriptor cannot be encoded.
package riscv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U,
        FMT_BAD
    } fmt_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] opcode);
        fmt_e f;
        case (opcode)
            OP_IMM, LOAD, JALR: f = FMT_I;
            STORE:              f = FMT_S;
            BRANCH:             f = FMT_B;
            JAL:                f = FMT_J;
            LUI, AUIPC:         f = FMT_U;
            OP:                 f = FMT_R;
            default:            f = FMT_BAD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/imm_encoder.sv
// Combinational immediate placement: checks that the immediate fits the format
// and scatters its bits into their instruction positions (all other bits zero).
module imm_encoder
    import riscv_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [31:0] imm,
    output logic        legal,
    output logic [31:0] bits
);

    // A field of width N+1 holds the value iff every bit above it equals the sign.
    logic fits_12;
    logic fits_13;
    logic fits_21;

    assign fits_12 = (&imm[31:11]) || !(|imm[31:11]);
    assign fits_13 = (&imm[31:12]) || !(|imm[31:12]);
    assign fits_21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        legal = 1'b0;
        bits  = 32'b0;
        case (fmt)
            FMT_R: begin
                legal = 1'b1;
                bits  = 32'b0;
            end
            FMT_I: begin
                legal = fits_12;
                bits  = {imm[11:0], 20'b0};
            end
            FMT_S: begin
                legal = fits_12;
                bits  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            end
            FMT_B: begin
                legal = fits_13 && !imm[0];
                bits  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            end
            FMT_J: begin
                legal = fits_21 && !imm[0];
                bits  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            end
            FMT_U: begin
                legal = !(|imm[11:0]);
                bits  = {imm[31:12], 12'b0};
            end
            default: begin
                legal = 1'b0;
                bits  = 32'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I assembler: turns field-level descriptors into 32-bit words
// with sequential write addresses through a single registered output stage.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              addr_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    fmt_e              fmt;
    logic              imm_legal;
    logic [31:0]       imm_bits;
    logic [31:0]       word;
    logic              accept;
    logic [ADDR_W-1:0] addr_cnt;

    assign fmt = opcode_fmt(in_opcode);

    imm_encoder u_imm (
        .fmt   (fmt),
        .imm   (in_imm),
        .legal (imm_legal),
        .bits  (imm_bits)
    );

    always_comb begin
        word = NOP;
        case (fmt)
            FMT_R:        word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I:        word = imm_bits | {12'b0, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S, FMT_B: word = imm_bits | {7'b0, in_rs2, in_rs1, in_funct3, 5'b0, in_opcode};
            FMT_J, FMT_U: word = imm_bits | {20'b0, in_rd, in_opcode};
            default:      word = NOP;
        endcase
        if (!imm_legal) begin
            word = NOP;
        end
    end

    // Handshake: a transfer happens on an edge where valid && ready. The output
    // register may reload in the same cycle its word is taken, so a full stream
    // flows without bubbles; a stalled word stays frozen until out_ready.
    assign in_ready = !rst && !addr_clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= 32'b0;
            out_addr  <= '0;
            out_err   <= 1'b0;
            err_count <= 8'd0;
            addr_cnt  <= ADDR_BASE;
        end else begin
            if (addr_clr) begin
                addr_cnt <= ADDR_BASE;
            end else if (accept) begin
                addr_cnt <= addr_cnt + ADDR_STEP;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= word;
                out_addr  <= addr_cnt;
                out_err   <= !imm_legal;
                if (!imm_legal && err_count != 8'd255) begin
                    err_count <= err_count + 8'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
